// File: rtl/cacheline_adaptor.sv
// Bridges a 256-bit cache line port to a 64-bit burst memory bus (4 beats per line).
// Optional mid-burst idle timeout is enabled by defining CLADAPT_TIMEOUT_EN.
module cacheline_adaptor #(
  parameter int BURST_W = 64,
  parameter int BEATS   = 4
`ifdef CLADAPT_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [BURST_W*BEATS-1:0]   line_i,
  output logic [BURST_W*BEATS-1:0]   line_o,
  input  logic [31:0]                address_i,
  input  logic                       read_i,
  input  logic                       write_i,
  output logic                       resp_o,
  output logic                       err_o,
  input  logic [BURST_W-1:0]         burst_i,
  output logic [BURST_W-1:0]         burst_o,
  output logic [31:0]                address_o,
  output logic                       read_o,
  output logic                       write_o,
  input  logic                       resp_i
);

  localparam int         LINE_W = BURST_W * BEATS;
  localparam logic [1:0] LAST   = 2'(BEATS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, DONE = 2'd3} state_t;

  state_t              r_state, w_state_nxt;
  logic [1:0]          r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [LINE_W-1:0]   r_line, w_line_nxt;
  logic [LINE_W-1:0]   r_line_o, w_line_o_nxt;
  logic [BURST_W-1:0]  r_burst_o, w_burst_nxt;
  logic [31:0]         r_addr_o, w_addr_nxt;
  logic                r_read_o, w_read_nxt;
  logic                r_write_o, w_write_nxt;
  logic                r_resp_o, w_resp_nxt;
  logic                r_err_o, w_err_nxt;
  logic                w_timeout;
  logic                w_unused_addr;

  assign w_cnt_inc     = r_cnt + 2'd1;
  assign w_unused_addr = ^address_i[4:0];

`ifdef CLADAPT_TIMEOUT_EN
  logic [7:0] r_idle;

  // Idle counter: runs only mid-burst, cleared by every memory strobe.
  always_ff @(posedge clk) begin
    if (rst)
      r_idle <= 8'd0;
    else if ((r_state == RD || r_state == WR) && !resp_i)
      r_idle <= r_idle + 8'd1;
    else
      r_idle <= 8'd0;
  end

  assign w_timeout = (r_state == RD || r_state == WR) && !resp_i &&
                     (r_idle == 8'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= 2'd0;
      r_line    <= '0;
      r_line_o  <= '0;
      r_burst_o <= '0;
      r_addr_o  <= 32'd0;
      r_read_o  <= 1'b0;
      r_write_o <= 1'b0;
      r_resp_o  <= 1'b0;
      r_err_o   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_line    <= w_line_nxt;
      r_line_o  <= w_line_o_nxt;
      r_burst_o <= w_burst_nxt;
      r_addr_o  <= w_addr_nxt;
      r_read_o  <= w_read_nxt;
      r_write_o <= w_write_nxt;
      r_resp_o  <= w_resp_nxt;
      r_err_o   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (write_i)      w_state_nxt = WR;
        else if (read_i)  w_state_nxt = RD;
        else              w_state_nxt = IDLE;
      end
      RD, WR: begin
        if ((resp_i && r_cnt == LAST) || w_timeout) w_state_nxt = DONE;
        else                                        w_state_nxt = r_state;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs; write wins when both requests are high.
  always_comb begin
    w_cnt_nxt    = r_cnt;
    w_line_nxt   = r_line;
    w_line_o_nxt = r_line_o;
    w_burst_nxt  = r_burst_o;
    w_addr_nxt   = r_addr_o;
    w_read_nxt   = r_read_o;
    w_write_nxt  = r_write_o;
    w_resp_nxt   = 1'b0;
    w_err_nxt    = 1'b0;
    case (r_state)
      IDLE: begin
        if (write_i) begin
          w_addr_nxt  = {address_i[31:5], 5'd0};
          w_line_nxt  = line_i;
          w_burst_nxt = line_i[BURST_W-1:0];
          w_write_nxt = 1'b1;
          w_cnt_nxt   = 2'd0;
        end else if (read_i) begin
          w_addr_nxt  = {address_i[31:5], 5'd0};
          w_read_nxt  = 1'b1;
          w_cnt_nxt   = 2'd0;
        end else begin
          w_cnt_nxt   = 2'd0;
        end
      end
      RD: begin
        if (resp_i) begin
          w_line_o_nxt[r_cnt*BURST_W +: BURST_W] = burst_i;
          w_cnt_nxt = w_cnt_inc;
          if (r_cnt == LAST) begin
            w_read_nxt = 1'b0;
            w_resp_nxt = 1'b1;
          end else begin
            w_read_nxt = 1'b1;
          end
        end else if (w_timeout) begin
          w_read_nxt = 1'b0;
          w_resp_nxt = 1'b1;
          w_err_nxt  = 1'b1;
          w_cnt_nxt  = 2'd0;
        end else begin
          w_read_nxt = 1'b1;
        end
      end
      WR: begin
        if (resp_i) begin
          w_cnt_nxt = w_cnt_inc;
          if (r_cnt == LAST) begin
            w_write_nxt = 1'b0;
            w_resp_nxt  = 1'b1;
          end else begin
            w_burst_nxt = r_line[w_cnt_inc*BURST_W +: BURST_W];
          end
        end else if (w_timeout) begin
          w_write_nxt = 1'b0;
          w_resp_nxt  = 1'b1;
          w_err_nxt   = 1'b1;
          w_cnt_nxt   = 2'd0;
        end else begin
          w_write_nxt = 1'b1;
        end
      end
      DONE: begin
        w_resp_nxt = 1'b0;
      end
      default: begin
        w_read_nxt  = 1'b0;
        w_write_nxt = 1'b0;
      end
    endcase
  end

  assign line_o    = r_line_o;
  assign burst_o   = r_burst_o;
  assign address_o = r_addr_o;
  assign read_o    = r_read_o;
  assign write_o   = r_write_o;
  assign resp_o    = r_resp_o;
  assign err_o     = r_err_o;

endmodule

// File: doc/cacheline_adaptor.md
Name: cacheline_adaptor

Overview:
- Bridges the L1 data cache's 256-bit line interface (line fill and write-back) to the 64-bit burst memory bus.
- A line read gathers 4 beats into a 256-bit line. A line write splits a 256-bit line into 4 beats.
- Sits directly downstream of the data cache datapath. Its line_o feeds the cache's fill data; its line_i, address_i and write_i are driven by the cache's eviction and miss path.

Parameters:
- BURST_W, 64, memory bus beat width in bits.
- BEATS, 4, beats per line; BURST_W*BEATS = 256.
- TIMEOUT_CYCLES, 255, idle cycles tolerated mid-burst; used only with CLADAPT_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- line_i  in  256  line to write back
- line_o  out  256  assembled fill line
- address_i  in  32  line request address
- read_i  in  1  line read request, level, held until resp_o
- write_i  in  1  line write request, level, held until resp_o
- resp_o  out  1  one-cycle completion pulse
- err_o  out  1  burst aborted (timeout build only)
- burst_i  in  64  read beat from memory
- burst_o  out  64  write beat to memory
- address_o  out  32  line-aligned memory address
- read_o  out  1  memory read burst request
- write_o  out  1  memory write burst request
- resp_i  in  1  memory beat strobe

Behaviour:
- All outputs are registered.
- Reset values: line_o=0, burst_o=0, address_o=0, read_o=0, write_o=0, resp_o=0, err_o=0, state=IDLE, beat counter=0.
- States: IDLE, RD, WR, DONE.
- IDLE: on a sampled request, latch address_o={address_i[31:5],5'b0}.
  - read_i: go to RD with read_o=1.
  - write_i: latch line_i, set burst_o=line_i[63:0], go to WR with write_o=1.
  - Both high: write wins (write-back precedes fill); read is not latched.
  - resp_i is ignored in IDLE and DONE.
- RD: each cycle with resp_i=1 stores burst_i into line_o[64k+63:64k], k = beat count 0..3, then increments k.
  - Beats need not be consecutive; cycles with resp_i=0 change nothing.
  - At the edge sampling the 4th beat: read_o=0, resp_o=1, go to DONE.
- WR: each cycle with resp_i=1 advances k, and burst_o takes the next 64-bit slice of the latched line.
  - At the 4th beat: write_o=0, burst_o holds its last value, resp_o=1, go to DONE.
- DONE: lasts one cycle, then resp_o=0 and go to IDLE. Requests are not accepted in DONE.
  - The requester must drop read_i/write_i in the cycle after resp_o.
- Minimum latency: request sampled at edge 0, read_o/write_o high from edge 0, 4 back-to-back beats at edges 1-4, resp_o high for the cycle after edge 4.
- line_o holds its value until the next read's first beat. The cache samples it while resp_o=1.
- Address and latched line are stable for the whole burst; changes on address_i/line_i mid-burst are ignored.
- Beat counter is 2 bits and wraps to 0 on the 4th beat. resp_i beyond 4 beats is impossible, because state has already left RD/WR.
- Reset mid-burst: next edge gives IDLE, read_o=write_o=0, counter=0. A partially assembled line_o is cleared to 0.

Optional Feature:
- Macro: CLADAPT_TIMEOUT_EN.
- With the macro: an 8-bit idle counter runs in RD/WR and clears on each resp_i.
  - When it reaches TIMEOUT_CYCLES without a beat: read_o/write_o=0, resp_o=1 and err_o=1 for one cycle, go to DONE.
  - line_o contents are then undefined-but-stable, holding the beats received so far.
- Without the macro: err_o is tied to 0, no counter exists, and a burst waits forever.

Test Plan:
- Read at address_i=0x12345678, four consecutive beats 0x1111...,0x2222...,0x3333...,0x4444... -> address_o=0x12345660; read_o high 4 cycles; resp_o pulses once; line_o = {0x4444..,0x3333..,0x2222..,0x1111..}.
- Write of line_i=256'h{D,C,B,A} with resp_i gapped (1,0,0,1,1,0,1) -> burst_o shows A,B,C,D in order, advancing only on resp_i; write_o drops and resp_o pulses after the 4th strobe.
- read_i and write_i both high in IDLE -> write_o=1, read_o=0; after resp_o, re-asserted read_i alone -> read burst follows.
- rst asserted after the 2nd read beat -> next cycle read_o=0, line_o=0; a fresh read then completes correctly from beat 0.
- Stray resp_i pulses in IDLE and DONE -> no state change, no resp_o.
- With CLADAPT_TIMEOUT_EN and TIMEOUT_CYCLES=8: read with no resp_i -> after 8 cycles read_o=0, resp_o=1, err_o=1 for one cycle. Without the macro the same stimulus leaves read_o high indefinitely and err_o=0.
